// File: rtl/debug_exec.sv
// debug_exec: executes one TAP debug op at a time (halt/resume/reset, per-channel memory read/write, register setup).
// Latency: register/illegal ops done at L+1; memory ops done the cycle after ack (or after TIMEOUT request cycles); RESET done at L+RESET_CYCLES+1.
// Backpressure: four-phase op_ready_async/op_done handshake toward the TAP; per-channel mem_req held until mem_ack or timeout.
//
// Ports:
//   cpu_clk, cpu_rstn          clock, synchronous active-low reset
//   op_ready_async, op, op_data TAP request level (2-FF synchronised), opcode and operand
//   op_done, op_err, result    completion level, error flag, last read data
//   dbg_busy                   state machine not idle
//   cpu_halt, cpu_reset_req    CPU halt level and reset pulse
//   mem_req/we/addr/wdata      per-channel memory request, flattened with channel c at slice c
//   mem_ack, mem_rdata         per-channel acknowledge and read data (same cycle)
module debug_exec #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int OP_W         = 8,
  parameter int NUM_MEM      = 2,
  parameter int TIMEOUT      = 255,
  parameter int RESET_CYCLES = 16
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rstn,
  input  logic                      op_ready_async,
  input  logic [OP_W-1:0]           op,
  input  logic [DATA_W-1:0]         op_data,
  output logic                      op_done,
  output logic                      op_err,
  output logic [DATA_W-1:0]         result,
  output logic                      dbg_busy,
  output logic                      cpu_halt,
  output logic                      cpu_reset_req,
  output logic [NUM_MEM-1:0]        mem_req,
  output logic [NUM_MEM-1:0]        mem_we,
  output logic [NUM_MEM*ADDR_W-1:0] mem_addr,
  output logic [NUM_MEM*DATA_W-1:0] mem_wdata,
  input  logic [NUM_MEM-1:0]        mem_ack,
  input  logic [NUM_MEM*DATA_W-1:0] mem_rdata
);

  // One counter serves both the memory timeout and the reset pulse length.
  localparam int CNT_MAX = (TIMEOUT > RESET_CYCLES) ? TIMEOUT : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RST  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sync1;
  logic                r_sync2;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_chan;
  logic                r_is_write;
  logic                r_op_err;
  logic                r_halt;
  logic                r_autoinc;
  logic [DATA_W-1:0]   r_result;
  logic [ADDR_W-1:0]   r_addr  [NUM_MEM];
  logic [DATA_W-1:0]   r_wdata [NUM_MEM];

  logic [3:0]          w_c;
  logic [OP_W-1:0]     w_op_hi;
  logic                w_hi_zero;
  logic                w_c_ok;
  logic                w_is_noop;
  logic                w_is_halt;
  logic                w_is_resume;
  logic                w_is_reset;
  logic                w_is_read;
  logic                w_is_write;
  logic                w_is_saddr;
  logic                w_is_swd;
  logic                w_is_ainc;
  logic                w_illegal;
  logic                w_launch;
  logic                w_ack_hit;
  logic                w_mem_ok;
  logic                w_tmo;
  logic [NUM_MEM-1:0]  w_sel;
  logic [DATA_W-1:0]   w_rdata;
  logic [ADDR_W-1:0]   w_op_addr;

  // ---------------- opcode decode (live op, used only at launch) ----------------
  assign w_c       = op[3:0];
  assign w_op_hi   = op >> 8;
  assign w_hi_zero = (w_op_hi == '0);
  assign w_c_ok    = ({1'b0, w_c} < 5'(NUM_MEM));

  always_comb begin
    w_is_noop   = 1'b0;
    w_is_halt   = 1'b0;
    w_is_resume = 1'b0;
    w_is_reset  = 1'b0;
    w_is_read   = 1'b0;
    w_is_write  = 1'b0;
    w_is_saddr  = 1'b0;
    w_is_swd    = 1'b0;
    w_is_ainc   = 1'b0;
    if (w_hi_zero) begin
      case (op[7:4])
        4'h0: begin
          w_is_noop   = (w_c == 4'h0);
          w_is_halt   = (w_c == 4'h1);
          w_is_resume = (w_c == 4'h2);
          w_is_reset  = (w_c == 4'h3);
        end
        4'h1:    w_is_read  = w_c_ok;
        4'h2:    w_is_write = w_c_ok;
        4'h8:    w_is_saddr = w_c_ok;
        4'h9:    w_is_swd   = w_c_ok;
        4'hA:    w_is_ainc  = (w_c == 4'h0);
        default: ;
      endcase
    end
  end

  assign w_illegal = ~(w_is_noop | w_is_halt | w_is_resume | w_is_reset | w_is_read |
                       w_is_write | w_is_saddr | w_is_swd | w_is_ainc);

  // Operand to address: truncate, or zero-extend when the address is wider.
  generate
    if (ADDR_W > DATA_W) begin : g_addr_ext
      assign w_op_addr = {{(ADDR_W-DATA_W){1'b0}}, op_data};
    end else begin : g_addr_trunc
      assign w_op_addr = op_data[ADDR_W-1:0];
    end
  endgenerate

  // ---------------- active channel ----------------
  assign w_sel     = NUM_MEM'(1) << r_chan;
  assign w_ack_hit = (r_state == S_MEM) && ((mem_ack & w_sel) != '0);

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_MEM; c++) begin
      if (r_chan == 4'(c)) w_rdata = mem_rdata[c*DATA_W +: DATA_W];
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_mem_ok    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sync2) begin
          w_launch = 1'b1;
          if (w_is_read || w_is_write) w_state_nxt = S_MEM;
          else if (w_is_reset)         w_state_nxt = S_RST;
          else                         w_state_nxt = S_DONE;
        end
      end
      S_MEM: begin
        // An ack in the last allowed request cycle still counts as success.
        if (w_ack_hit) begin
          w_mem_ok    = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_RST: begin
        if (r_cnt == CNT_W'(RESET_CYCLES - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Request drops seen earlier are only acted on here.
        if (!r_sync2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_chan     <= '0;
      r_is_write <= 1'b0;
      r_op_err   <= 1'b0;
      r_halt     <= 1'b0;
      r_autoinc  <= 1'b0;
      r_result   <= '0;
      for (int c = 0; c < NUM_MEM; c++) begin
        r_addr[c]  <= '0;
        r_wdata[c] <= '0;
      end
    end else begin
      r_sync1 <= op_ready_async;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;

      if (w_launch) r_cnt <= '0;
      else if (r_state == S_MEM || r_state == S_RST) r_cnt <= r_cnt + CNT_W'(1);

      if (w_launch) begin
        r_op_err   <= w_illegal;
        r_chan     <= w_c;
        r_is_write <= w_is_write;
        if (w_is_halt)   r_halt    <= 1'b1;
        if (w_is_resume) r_halt    <= 1'b0;
        if (w_is_ainc)   r_autoinc <= op_data[0];
        for (int c = 0; c < NUM_MEM; c++) begin
          if (w_is_saddr && w_c == 4'(c)) r_addr[c]  <= w_op_addr;
          if (w_is_swd   && w_c == 4'(c)) r_wdata[c] <= op_data;
        end
      end

      if (w_mem_ok) begin
        if (!r_is_write) r_result <= w_rdata;
        if (r_autoinc) begin
          for (int c = 0; c < NUM_MEM; c++) begin
            if (r_chan == 4'(c)) r_addr[c] <= r_addr[c] + ADDR_W'(1);
          end
        end
      end

      if (w_tmo) r_op_err <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign op_done       = (r_state == S_DONE);
  assign dbg_busy      = (r_state != S_IDLE);
  assign cpu_reset_req = (r_state == S_RST);
  assign op_err        = r_op_err;
  assign result        = r_result;
  assign cpu_halt      = r_halt;
  assign mem_req       = (r_state == S_MEM) ? w_sel : '0;
  assign mem_we        = (r_state == S_MEM && r_is_write) ? w_sel : '0;

  generate
    for (genvar g = 0; g < NUM_MEM; g++) begin : g_chan_out
      assign mem_addr[g*ADDR_W +: ADDR_W]  = r_addr[g];
      assign mem_wdata[g*DATA_W +: DATA_W] = r_wdata[g];
    end
  endgenerate

endmodule

// File: tb/tb_debug_exec.sv
// tb_debug_exec: randomized + directed stimulus for debug_exec, scoreboard checked by a separate monitor.
// Latency: each op is expected to complete at a model-computed number of edges after the request is raised.
// Backpressure: bench memory acks after a programmed number of request cycles (0 = never, forcing timeout).
module tb_debug_exec;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int OW = 10;
  localparam int NM = 2;
  localparam int TO = 4;
  localparam int RC = 16;

  logic              cpu_clk = 1'b0;
  logic              cpu_rstn;
  logic              op_ready_async;
  logic [OW-1:0]     op;
  logic [DW-1:0]     op_data;
  logic              op_done, op_err, dbg_busy, cpu_halt, cpu_reset_req;
  logic [DW-1:0]     result;
  logic [NM-1:0]     mem_req, mem_we, mem_ack;
  logic [NM*AW-1:0]  mem_addr;
  logic [NM*DW-1:0]  mem_wdata, mem_rdata;

  debug_exec #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .NUM_MEM(NM),
               .TIMEOUT(TO), .RESET_CYCLES(RC)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .op_ready_async(op_ready_async),
    .op(op), .op_data(op_data), .op_done(op_done), .op_err(op_err), .result(result),
    .dbg_busy(dbg_busy), .cpu_halt(cpu_halt), .cpu_reset_req(cpu_reset_req),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic          err;
    logic          halt;
    logic [DW-1:0] result;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            edges;
    int            req;
    int            rst;
    logic          we;
    logic [NM-1:0] mask;
    logic          chk_wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] m_addr  [NM];
  logic [DW-1:0] m_wdata [NM];
  logic [DW-1:0] m_result;
  logic          m_halt;
  logic          m_autoinc;

  task automatic model_reset();
    for (int c = 0; c < NM; c++) begin
      m_addr[c]  = '0;
      m_wdata[c] = '0;
    end
    m_result  = '0;
    m_halt    = 1'b0;
    m_autoinc = 1'b0;
  endtask

  // Effect of one op on the architectural state plus the expected timing,
  // expressed in edges from the request rise (2 synchroniser edges + op latency).
  task automatic model(input logic [OW-1:0] o, input logic [DW-1:0] d, input int dly,
                       input logic [DW-1:0] rd, output exp_t e);
    int   c;
    logic [3:0] g;
    bit   is_mem, is_wr;
    c = int'(o[3:0]);
    g = o[7:4];
    is_mem = 0; is_wr = 0;
    e.err = 0; e.edges = 3; e.req = 0; e.rst = 0; e.we = 0; e.mask = '0;
    e.chk_wr = 0; e.wa = '0; e.wd = '0;
    if (o[OW-1:8] != '0)                 e.err = 1;
    else if (o[7:0] == 8'h00)            ;
    else if (o[7:0] == 8'h01)            m_halt = 1'b1;
    else if (o[7:0] == 8'h02)            m_halt = 1'b0;
    else if (o[7:0] == 8'h03) begin      e.rst = RC; e.edges = 2 + RC + 1; end
    else if (g == 4'h1 && c < NM)        is_mem = 1;
    else if (g == 4'h2 && c < NM) begin  is_mem = 1; is_wr = 1; end
    else if (g == 4'h8 && c < NM)        m_addr[c] = d[AW-1:0];
    else if (g == 4'h9 && c < NM)        m_wdata[c] = d;
    else if (o[7:0] == 8'hA0)            m_autoinc = d[0];
    else                                 e.err = 1;
    if (is_mem) begin
      e.mask = NM'(1) << c;
      e.we   = is_wr;
      if (dly >= 1 && dly <= TO) begin
        e.req   = dly;
        e.edges = 2 + dly + 1;
        if (is_wr) begin
          e.chk_wr = 1; e.wa = m_addr[c]; e.wd = m_wdata[c];
        end else begin
          m_result = rd;
        end
        if (m_autoinc) m_addr[c] = AW'(m_addr[c] + 1);
      end else begin
        e.req   = TO;
        e.edges = 2 + TO + 1;
        e.err   = 1;
      end
    end
    e.halt = m_halt; e.result = m_result;
    e.a0 = m_addr[0]; e.a1 = m_addr[1]; e.d0 = m_wdata[0]; e.d1 = m_wdata[1];
  endtask

  // ---------------- memory responder ----------------
  int            ack_delay = 1;
  logic [DW-1:0] ack_rdata = '0;
  int            req_cnt, rst_cnt;
  logic          we_seen;
  logic [NM-1:0] req_mask;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_wdata;

  initial begin
    logic prev_rdy;
    prev_rdy = 1'b0;
    mem_ack = '0; mem_rdata = '0;
    req_cnt = 0; rst_cnt = 0; we_seen = 0; req_mask = '0; seen_addr = '0; seen_wdata = '0;
    forever begin
      @(negedge cpu_clk);
      if (op_ready_async && !prev_rdy) begin
        req_cnt = 0; rst_cnt = 0; we_seen = 0; req_mask = '0;
      end
      prev_rdy  = op_ready_async;
      // Acks on idle channels are noise the DUT must ignore.
      mem_ack   = NM'($urandom) & ~mem_req;
      mem_rdata = {$urandom, $urandom};
      if (mem_req != '0) begin
        req_cnt++;
        req_mask = req_mask | mem_req;
        if (mem_we != '0) we_seen = 1'b1;
        if (req_cnt == ack_delay) begin
          mem_ack = mem_ack | mem_req;
          for (int c = 0; c < NM; c++) begin
            if (mem_req[c]) begin
              mem_rdata[c*DW +: DW] = ack_rdata;
              seen_addr  = mem_addr[c*AW +: AW];
              seen_wdata = mem_wdata[c*DW +: DW];
            end
          end
        end
      end
      if (cpu_reset_req) rst_cnt++;
    end
  end

  // ---------------- monitor ----------------
  int raise_cyc = 0;

  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(posedge cpu_clk); #1;
      if (op_done && !prev_done) begin
        if (q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done: op_done rose with nothing pending (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("done_edges",   64'(cyc - raise_cyc), 64'(e.edges));
          chk("op_err",       64'(op_err),   64'(e.err));
          chk("result",       64'(result),   64'(e.result));
          chk("cpu_halt",     64'(cpu_halt), 64'(e.halt));
          chk("addr0",        64'(mem_addr[AW-1:0]),     64'(e.a0));
          chk("addr1",        64'(mem_addr[2*AW-1:AW]),  64'(e.a1));
          chk("wdata0",       64'(mem_wdata[DW-1:0]),    64'(e.d0));
          chk("wdata1",       64'(mem_wdata[2*DW-1:DW]), 64'(e.d1));
          chk("req_cycles",   64'(req_cnt),  64'(e.req));
          chk("req_channel",  64'(req_mask), 64'(e.mask));
          chk("we_seen",      64'(we_seen),  64'(e.we));
          chk("rst_cycles",   64'(rst_cnt),  64'(e.rst));
          chk("busy_at_done", 64'(dbg_busy), 64'(1));
          chk("req_at_done",  64'(mem_req),  64'(0));
          if (e.chk_wr) begin
            chk("wr_addr", 64'(seen_addr),  64'(e.wa));
            chk("wr_data", 64'(seen_wdata), 64'(e.wd));
          end
        end
      end
      prev_done = op_done;
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [OW-1:0] o, input logic [DW-1:0] d, input int dly,
                       input logic [DW-1:0] rd, input bit early);
    exp_t e;
    int   n;
    bit   early_eff;
    ack_delay = dly;
    ack_rdata = rd;
    model(o, d, dly, rd, e);
    early_eff = early && (e.edges >= 6);
    q.push_back(e);
    @(posedge cpu_clk); #1;
    op = o; op_data = d; op_ready_async = 1'b1; raise_cyc = cyc;
    n = 0;
    while (op_done !== 1'b1 && n < 200) begin
      @(posedge cpu_clk); #1; n++;
      // Dropping the request right after launch must not disturb the op.
      if (early_eff && n == 3) op_ready_async = 1'b0;
    end
    if (n >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: op 0x%0h never completed", o);
    end
    op_ready_async = 1'b0;
    n = 0;
    while (op_done !== 1'b0 && n < 20) begin
      @(posedge cpu_clk); #1; n++;
    end
    chk("done_fall", 64'(op_done), 64'(0));
    if (!early_eff) chk("done_fall_edges", 64'(n), 64'(3));
    chk("busy_idle", 64'(dbg_busy), 64'(0));
  endtask

  initial begin
    logic [OW-1:0] o;
    int            k, n, ch;
    cpu_rstn = 1'b0; op_ready_async = 1'b0; op = '0; op_data = '0;
    model_reset();

    // Reset dominates a live request; every output stays at zero.
    op = 10'h001; op_ready_async = 1'b1;
    repeat (4) @(posedge cpu_clk);
    #1;
    chk("rst_op_done",  64'(op_done),  64'(0));
    chk("rst_op_err",   64'(op_err),   64'(0));
    chk("rst_result",   64'(result),   64'(0));
    chk("rst_busy",     64'(dbg_busy), 64'(0));
    chk("rst_halt",     64'(cpu_halt), 64'(0));
    chk("rst_rreq",     64'(cpu_reset_req), 64'(0));
    chk("rst_mem_req",  64'(mem_req),  64'(0));
    chk("rst_mem_we",   64'(mem_we),   64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wd",   mem_wdata,     64'(0));
    op_ready_async = 1'b0;
    cpu_rstn = 1'b1;
    @(posedge cpu_clk);

    // Directed: halt, write/read on channel 1, autoinc wrap, timeout, illegal, reset.
    do_op(10'h001, 32'h0, 1, 32'h0, 0);
    do_op(10'h081, 32'h0000_1000, 1, 32'h0, 0);
    do_op(10'h091, 32'hDEAD_BEEF, 1, 32'h0, 0);
    do_op(10'h021, 32'h0, 3, 32'h0, 0);
    do_op(10'h011, 32'h0, 2, 32'hCAFE_F00D, 0);
    do_op(10'h0A0, 32'h1, 1, 32'h0, 0);
    do_op(10'h080, 32'h1234_FFFF, 1, 32'h0, 0);
    do_op(10'h010, 32'h0, 1, 32'h1111_2222, 0);
    do_op(10'h010, 32'h0, 0, 32'h3333_4444, 0);
    do_op(10'h010, 32'h0, 4, 32'h5555_6666, 0);
    do_op(10'h01F, 32'hFFFF_FFFF, 1, 32'h0, 0);
    do_op(10'h055, 32'hFFFF_FFFF, 1, 32'h0, 0);
    do_op(10'h110, 32'h0, 1, 32'h0, 0);
    do_op(10'h012, 32'h0, 1, 32'h0, 0);
    do_op(10'h003, 32'h0, 1, 32'h0, 0);
    do_op(10'h002, 32'h0, 1, 32'h0, 0);

    // Randomized ops.
    for (int i = 0; i < 50; i++) begin
      ch = $urandom_range(0, 2);
      case ($urandom_range(0, 7))
        0:       o = OW'($urandom_range(0, 3));
        1, 7:    o = {2'b00, 4'h1, 4'(ch)};
        2:       o = {2'b00, 4'h2, 4'(ch)};
        3:       o = {2'b00, 4'h8, 4'(ch)};
        4:       o = {2'b00, 4'h9, 4'(ch)};
        5:       o = 10'h0A0;
        default: o = OW'($urandom);
      endcase
      do_op(o, $urandom, $urandom_range(0, 5), $urandom, ($urandom_range(0, 3) == 0));
    end

    // Reset in the 8th cycle of a CPU reset pulse.
    ack_delay = 0;
    @(posedge cpu_clk); #1;
    op = 10'h003; op_ready_async = 1'b1;
    k = 0; n = 0;
    while (k < 8 && n < 100) begin
      @(posedge cpu_clk); #1; n++;
      if (cpu_reset_req) k++;
    end
    chk("pulse_reached_8", 64'(k), 64'(8));
    cpu_rstn = 1'b0;
    @(posedge cpu_clk); #1;
    chk("midrst_reset_req", 64'(cpu_reset_req), 64'(0));
    chk("midrst_busy",      64'(dbg_busy),      64'(0));
    chk("midrst_done",      64'(op_done),       64'(0));
    chk("midrst_halt",      64'(cpu_halt),      64'(0));
    @(posedge cpu_clk); #1;
    op_ready_async = 1'b0;
    cpu_rstn = 1'b1;
    repeat (6) begin
      @(posedge cpu_clk); #1;
      chk("no_done_after_rst", 64'(op_done), 64'(0));
    end

    chk("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debug_exec.md
# debug_exec

Parametrised debug command executor for the CPU clock domain. It accepts one debug operation at a time from the JTAG TAP over a four-phase request/done handshake, synchronising the request level internally. It drives halt and reset requests to the CPU and services read and write commands on `NUM_MEM` independent memory channels with req/ack flow control. It returns read data and error status to the TAP, and supports optional address auto-increment for burst access.

## Interface
- `DATA_W`, default 32: debug data, write data and read data width.
- `ADDR_W`, default 32: per-channel address width.
- `OP_W`, default 8: opcode width, at least 8; bits above [7:0] must be zero or the op is illegal.
- `NUM_MEM`, default 2: memory channel count, 1..16.
- `TIMEOUT`, default 255: maximum cycles `mem_req` is held without `mem_ack`, at least 1.
- `RESET_CYCLES`, default 16: length of the `cpu_reset_req` pulse, at least 1.

Ports:
- `cpu_clk`, in, 1: the only clock.
- `cpu_rstn`, in, 1: reset, synchronous, active-low.
- `op_ready_async`, in, 1: request level from the TAP domain; passes through a 2-FF synchroniser to become `ready_sync`.
- `op`, in, `OP_W`: opcode; must be stable while the request is high.
- `op_data`, in, `DATA_W`: operand; must be stable while the request is high.
- `op_done`, out, 1: completion level returned to the TAP.
- `op_err`, out, 1: the last op was illegal or timed out.
- `result`, out, `DATA_W`: data from the last successful read.
- `dbg_busy`, out, 1: state is not IDLE.
- `cpu_halt`, out, 1: halt request level to the CPU.
- `cpu_reset_req`, out, 1: CPU reset pulse.
- `mem_req`, out, `NUM_MEM`: per-channel request.
- `mem_we`, out, `NUM_MEM`: per-channel write enable; valid only while `mem_req` is high.
- `mem_addr`, out, `NUM_MEM*ADDR_W`: channel c occupies slice `[c*ADDR_W +: ADDR_W]`.
- `mem_wdata`, out, `NUM_MEM*DATA_W`: same slicing as `mem_addr`.
- `mem_ack`, in, `NUM_MEM`: per-channel acknowledge.
- `mem_rdata`, in, `NUM_MEM*DATA_W`: per-channel read data; valid in the same cycle as `mem_ack`.

## Operation
Opcodes (c = channel index in op[3:0]):
- 0x00 NOOP, 0x01 HALT (sets `cpu_halt`), 0x02 RESUME (clears `cpu_halt`), 0x03 RESET (pulses `cpu_reset_req`; `cpu_halt` is unchanged).
- 0x10+c READ, 0x20+c WRITE.
- 0x80+c STORE_ADDR: `addr[c] <= op_data[ADDR_W-1:0]`, zero-extended if `ADDR_W > DATA_W`.
- 0x90+c STORE_WDATA: `wdata[c] <= op_data`.
- 0xA0 SET_AUTOINC: `autoinc <= op_data[0]`.
- Any other code, any c ≥ `NUM_MEM`, or any nonzero high opcode bit is illegal: no side effects, `op_err` = 1.

State machine, states IDLE, MEM, RST, DONE:
- IDLE → launch when `ready_sync` = 1 and `op_done` = 0. `op` and `op_data` are captured at launch and `op_err` is cleared.
- Register ops, NOOP, HALT, RESUME and illegal ops complete at launch and go to DONE.
- READ/WRITE → MEM. `mem_req[c]` is high with `mem_we[c]` = 1 for WRITE.
- MEM, on `mem_ack[c]`: READ latches `result` from `mem_rdata[c]`. If `autoinc` is set, `addr[c] += 1`, wrapping modulo 2^`ADDR_W`. Then → DONE.
- MEM, on timeout: no ack after `TIMEOUT` request cycles drops `mem_req`, sets `op_err`, leaves `addr` and `result` unchanged, and → DONE.
- RESET → RST for `RESET_CYCLES` cycles, then → DONE.
- DONE: `op_done` = 1. When `ready_sync` = 0, clear `op_done` and → IDLE.
- `mem_ack` on channels that are not being requested is ignored.
- `mem_addr` and `mem_wdata` continuously reflect the stored per-channel registers.
- A deassertion of the request before DONE is held off until DONE is reached and has no effect on the op in progress.

## Timing
- Reset: every output and internal register resets to 0, including `autoinc`, the synchroniser and the state (IDLE). Reset mid-operation drops `mem_req` and `cpu_reset_req` on the next edge, and no `op_done` is produced.
- Synchroniser: `ready_sync` follows `op_ready_async` after 2 edges.
- Cycle L is the first cycle in IDLE with the launch condition true.
- Register ops: the register update and `op_done` = 1 are visible in L+1.
- Memory ops:
  - `mem_req` is high from L+1.
  - An ack sampled in cycle A drops `mem_req` in A+1, and `result`, the incremented `addr` and `op_done` are visible in A+1.
  - Zero-wait ack at A = L+1 gives `op_done` in L+2.
  - Timeout: `mem_req` is high for cycles L+1..L+`TIMEOUT`. If there is no ack, `op_err` = 1 and `op_done` = 1 are visible in L+`TIMEOUT`+1.
  - An ack in cycle L+`TIMEOUT` is a success.
- RESET: `cpu_reset_req` is high in cycles L+1..L+`RESET_CYCLES`, and `op_done` is visible in L+`RESET_CYCLES`+1.
- `op_done` falls one edge after `ready_sync` is seen low. The next launch is possible one cycle later.
- `dbg_busy` is high from L+1 until the cycle in which `op_done` falls.

## Test plan
- Reset and synchroniser: hold `cpu_rstn` low, then raise `op_ready_async` with op 0x01 → all outputs 0 during reset; after reset, `cpu_halt` = 1 and `op_done` = 1 three edges after the raise; dropping the request → `op_done` = 0.
- Write then read, channel 1: STORE_ADDR 0x1000, STORE_WDATA 0xDEADBEEF, WRITE (0x21) with ack after 3 cycles → `mem_req[1]` high for exactly 3 cycles and `mem_we[1]` = 1; then READ (0x11) with rdata 0xCAFEF00D → `result` = 0xCAFEF00D and `op_err` = 0.
- Auto-increment wrap: `ADDR_W` = 8, SET_AUTOINC 1, STORE_ADDR 0xFF, READ with zero-wait ack → channel 0 `addr` = 0x00 afterwards; `op_done` arrives 2 cycles after launch.
- Timeout, `TIMEOUT` = 4, READ with no ack → `mem_req` high for 4 cycles, then `op_err` = 1 and `result` unchanged; a repeat with ack in the 4th cycle → success with `op_err` = 0.
- Illegal op: opcode 0x1F with `NUM_MEM` = 2, then 0x55 → `op_err` = 1 each time, no `mem_req`, all registers unchanged.
- RESET, `RESET_CYCLES` = 16 → `cpu_reset_req` high for exactly 16 cycles and `cpu_halt` preserved; asserting `cpu_rstn` low in the 8th cycle → `cpu_reset_req` = 0 on the next edge, state IDLE, no `op_done`.
